// File: rtl/bram_port_arbiter_if.sv
// Requester-side and BRAM-side signals of the two-master port-0 arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface bram_port_arbiter_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 7
);
    logic              i_req0;
    logic              i_req1;
    logic              i_we0;
    logic              i_we1;
    logic [AWIDTH-1:0] i_addr0;
    logic [AWIDTH-1:0] i_addr1;
    logic [DWIDTH-1:0] i_wdata0;
    logic [DWIDTH-1:0] i_wdata1;
    logic              o_gnt0;
    logic              o_gnt1;
    logic              o_rvalid0;
    logic              o_rvalid1;
    logic [DWIDTH-1:0] o_rdata0;
    logic [DWIDTH-1:0] o_rdata1;
    logic [AWIDTH-1:0] addr0;
    logic              ce0;
    logic              we0;
    logic [DWIDTH-1:0] d0;
    logic [DWIDTH-1:0] q0;

    modport slave (
        input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, q0,
        output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
        output addr0, ce0, we0, d0
    );

    modport master (
        output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, q0,
        input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
        input  addr0, ce0, we0, d0
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with bounded bursts sharing BRAM port 0 between two
// requesters; read data is steered back to its issuer two cycles after grant.
module bram_port_arbiter #(
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 7,
    parameter int MEM_SIZE  = 128,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    bram_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]   BURST_MAX = CW'(MAX_BURST);
    localparam logic [AWIDTH:0] MEM_LIM   = (AWIDTH + 1)'(MEM_SIZE);

    typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} owner_t;

    owner_t            owner, owner_nxt;
    logic              cont, cont_nxt;
    logic [CW-1:0]     burst_cnt, burst_nxt;
    logic              gnt0, gnt1, port_en, sel, sel_we, in_range;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;
    logic              vld_p1, id_p1, oob_p1;
    logic              vld0_p2, vld1_p2;
    logic [DWIDTH-1:0] rdata0_p2, rdata1_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN1;
            cont      <= 1'b0;
            burst_cnt <= '0;
        end else begin
            owner     <= owner_nxt;
            cont      <= cont_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        owner_nxt = owner;
        cont_nxt  = 1'b0;
        burst_nxt = '0;
        if (!reset) begin
            if (bus.i_req0 && bus.i_req1) begin
                // Owner keeps the port only while its burst is still running.
                if (cont && (burst_cnt < BURST_MAX)) begin
                    gnt0 = (owner == OWN0);
                    gnt1 = (owner == OWN1);
                end else begin
                    gnt0 = (owner == OWN1);
                    gnt1 = (owner == OWN0);
                end
            end else begin
                gnt0 = bus.i_req0;
                gnt1 = bus.i_req1;
            end
        end
        if (gnt0 || gnt1) begin
            cont_nxt = 1'b1;
            if ((gnt1 ? OWN1 : OWN0) == owner) begin
                burst_nxt = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
            end else begin
                owner_nxt = gnt1 ? OWN1 : OWN0;
                burst_nxt = CW'(1);
            end
        end
    end

    // p0: command mux onto the BRAM port, same cycle as the grant
    always_comb begin
        port_en   = gnt0 | gnt1;
        sel       = gnt1;
        sel_we    = sel ? bus.i_we1    : bus.i_we0;
        sel_addr  = sel ? bus.i_addr1  : bus.i_addr0;
        sel_wdata = sel ? bus.i_wdata1 : bus.i_wdata0;
        in_range  = ({1'b0, sel_addr} < MEM_LIM);
        bus.o_gnt0 = gnt0;
        bus.o_gnt1 = gnt1;
        bus.ce0    = port_en & in_range;
        bus.we0    = port_en & in_range & sel_we;
        bus.addr0  = port_en ? sel_addr  : '0;
        bus.d0     = port_en ? sel_wdata : '0;
    end

    // p1: read tag travels while the BRAM fetches; p2: steer q0 to the issuer
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            id_p1     <= 1'b0;
            oob_p1    <= 1'b0;
            vld0_p2   <= 1'b0;
            vld1_p2   <= 1'b0;
            rdata0_p2 <= '0;
            rdata1_p2 <= '0;
        end else begin
            vld_p1  <= port_en & ~sel_we;
            id_p1   <= sel;
            oob_p1  <= ~in_range;
            vld0_p2 <= vld_p1 & ~id_p1;
            vld1_p2 <= vld_p1 & id_p1;
            if (vld_p1 && !id_p1) rdata0_p2 <= oob_p1 ? '0 : bus.q0;
            if (vld_p1 && id_p1)  rdata1_p2 <= oob_p1 ? '0 : bus.q0;
        end
    end

    assign bus.o_rvalid0 = vld0_p2;
    assign bus.o_rvalid1 = vld1_p2;
    assign bus.o_rdata0  = rdata0_p2;
    assign bus.o_rdata1  = rdata1_p2;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus a randomized run against
// a grant-history / shadow-memory reference model, with a behavioural BRAM.
module tb_bram_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 7;
    localparam int MS = 100;
    localparam int MB = 4;

    typedef struct {
        int          cyc;
        int          id;
        logic [DW-1:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_clr = 1'b1;
    logic [DW-1:0] mem [128];
    int total = 0;
    int bad = 0;
    int hist[$];

    always #5 clk = ~clk;

    bram_port_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    bram_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // single-port BRAM with one cycle read latency
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
            bus.q0 <= '0;
        end else if (bus.ce0) begin
            if (bus.we0) mem[bus.addr0] <= bus.d0;
            else         bus.q0 <= mem[bus.addr0];
        end
    end

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_req0 = 1'b0; bus.i_we0 = 1'b0; bus.i_addr0 = '0; bus.i_wdata0 = '0;
        bus.i_req1 = 1'b0; bus.i_we1 = 1'b0; bus.i_addr1 = '0; bus.i_wdata1 = '0;
    endtask

    task automatic req0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_req0 = 1'b1; bus.i_we0 = we; bus.i_addr0 = a; bus.i_wdata0 = d;
    endtask

    task automatic req1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_req1 = 1'b1; bus.i_we1 = we; bus.i_addr1 = a; bus.i_wdata1 = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cyc_start();
        reset = 1'b0;
    endtask

    // Arbitration from the grant history: free choice after idle goes away
    // from the last winner; a running streak keeps the port until MB long.
    function automatic int model_pick(input bit r0, input bit r1);
        int last, run, owner;
        if (!r0 && !r1) return -1;
        if (r0 != r1) return r0 ? 0 : 1;
        owner = 1;
        for (int i = 0; i < hist.size(); i++) if (hist[i] >= 0) owner = hist[i];
        last = (hist.size() > 0) ? hist[hist.size()-1] : -1;
        if (last < 0) return 1 - owner;
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == last; i--) run++;
        return (run < MB) ? last : 1 - last;
    endfunction

    task automatic test_reset();
        logic [3+2*AW+4*DW:0] obs;
        reset = 1'b1;
        mem_clr = 1'b1;
        req0(1'b1, 7'd3, 16'h1234);
        req1(1'b0, 7'd4, 16'h5678);
        for (int i = 0; i < 2; i++) begin
            #4;
            obs = {bus.o_gnt0, bus.o_gnt1, bus.ce0, bus.we0, bus.o_rvalid0, bus.o_rvalid1,
                   bus.addr0, bus.d0, bus.o_rdata0, bus.o_rdata1};
            total++;
            if (obs !== '0) begin bad++; $display("FAIL reset_outputs cyc%0d got=%h exp=0", i, obs); end
            cyc_start();
        end
        mem_clr = 1'b0;
        reset = 1'b0;
        #4;
        total++;
        if ({bus.o_gnt0, bus.o_gnt1} !== 2'b10) begin
            bad++; $display("FAIL reset_first_gnt got=%b exp=10", {bus.o_gnt0, bus.o_gnt1});
        end
        idle();
        cyc_start();
    endtask

    task automatic test_write_read();
        do_reset();
        req0(1'b1, 7'd5, 16'hA5A5);
        #4;
        total++;
        if ({bus.o_gnt0, bus.o_gnt1, bus.ce0, bus.we0, bus.addr0, bus.d0} !== {4'b1011, 7'd5, 16'hA5A5}) begin
            bad++; $display("FAIL wr_cmd got=%b%b%b%b a=%0d d=%h exp=1011 a=5 d=a5a5",
                            bus.o_gnt0, bus.o_gnt1, bus.ce0, bus.we0, bus.addr0, bus.d0);
        end
        cyc_start();
        req0(1'b0, 7'd5, 16'h0);
        #4;
        total++;
        if ({bus.o_gnt0, bus.ce0, bus.we0, bus.addr0} !== {3'b110, 7'd5}) begin
            bad++; $display("FAIL rd_cmd got=%b%b%b a=%0d exp=110 a=5", bus.o_gnt0, bus.ce0, bus.we0, bus.addr0);
        end
        cyc_start();
        idle();
        #4;
        total++;
        if ({bus.o_rvalid0, bus.o_rvalid1} !== 2'b00) begin
            bad++; $display("FAIL rd_early got=%b exp=00", {bus.o_rvalid0, bus.o_rvalid1});
        end
        cyc_start();
        #4;
        total++;
        if ({bus.o_rvalid0, bus.o_rvalid1, bus.o_rdata0} !== {2'b10, 16'hA5A5}) begin
            bad++; $display("FAIL rd_resp got=%b%b d=%h exp=10 d=a5a5", bus.o_rvalid0, bus.o_rvalid1, bus.o_rdata0);
        end
        cyc_start();
        #4;
        total++;
        if ({bus.o_rvalid0, bus.o_rdata0} !== {1'b0, 16'hA5A5}) begin
            bad++; $display("FAIL rd_hold got=%b d=%h exp=0 d=a5a5", bus.o_rvalid0, bus.o_rdata0);
        end
        cyc_start();
    endtask

    task automatic test_burst();
        int exp;
        do_reset();
        req0(1'b0, 7'd1, 16'h0);
        req1(1'b0, 7'd2, 16'h0);
        for (int i = 0; i < 12; i++) begin
            exp = (i / MB) % 2;
            #4;
            total++;
            if ({bus.o_gnt0, bus.o_gnt1} !== {exp == 0, exp == 1}) begin
                bad++; $display("FAIL burst_seq cyc%0d got=%b%b exp_id=%0d", i, bus.o_gnt0, bus.o_gnt1, exp);
            end
            cyc_start();
        end
        idle();
        cyc_start();
    endtask

    task automatic test_drop();
        // req1 pattern and expected grant id after requester 0 last owned the port
        bit r1_tab[7]  = '{1, 1, 0, 0, 1, 1, 1};
        int exp_tab[7] = '{1, 1, 0, 0, 0, 0, 1};
        do_reset();
        req0(1'b0, 7'd3, 16'h0);
        cyc_start();
        idle();
        cyc_start();
        for (int i = 0; i < 7; i++) begin
            req0(1'b0, 7'd3, 16'h0);
            if (r1_tab[i]) req1(1'b0, 7'd4, 16'h0);
            else bus.i_req1 = 1'b0;
            #4;
            total++;
            if ({bus.o_gnt0, bus.o_gnt1} !== {exp_tab[i] == 0, exp_tab[i] == 1}) begin
                bad++; $display("FAIL drop_seq cyc%0d got=%b%b exp_id=%0d", i, bus.o_gnt0, bus.o_gnt1, exp_tab[i]);
            end
            cyc_start();
        end
        idle();
        cyc_start();
    endtask

    task automatic test_mixed_reads();
        do_reset();
        req0(1'b1, 7'd10, 16'h1111);
        #4;
        total++;
        if (bus.o_gnt0 !== 1'b1) begin bad++; $display("FAIL mix_wr0 got=%b exp=1", bus.o_gnt0); end
        cyc_start();
        idle();
        req1(1'b1, 7'd20, 16'h2222);
        #4;
        total++;
        if (bus.o_gnt1 !== 1'b1) begin bad++; $display("FAIL mix_wr1 got=%b exp=1", bus.o_gnt1); end
        cyc_start();
        idle();
        req0(1'b0, 7'd10, 16'h0);
        cyc_start();
        idle();
        req1(1'b0, 7'd20, 16'h0);
        cyc_start();
        idle();
        #4;
        total++;
        if ({bus.o_rvalid0, bus.o_rvalid1, bus.o_rdata0} !== {2'b10, 16'h1111}) begin
            bad++; $display("FAIL mix_r0 got=%b%b d=%h exp=10 d=1111", bus.o_rvalid0, bus.o_rvalid1, bus.o_rdata0);
        end
        cyc_start();
        #4;
        total++;
        if ({bus.o_rvalid0, bus.o_rvalid1, bus.o_rdata1, bus.o_rdata0} !== {2'b01, 16'h2222, 16'h1111}) begin
            bad++; $display("FAIL mix_r1 got=%b%b d1=%h d0=%h exp=01 d1=2222 d0=1111",
                            bus.o_rvalid0, bus.o_rvalid1, bus.o_rdata1, bus.o_rdata0);
        end
        cyc_start();
    endtask

    task automatic test_out_of_range();
        req0(1'b0, 7'd110, 16'h0);
        #4;
        total++;
        if ({bus.o_gnt0, bus.ce0, bus.we0} !== 3'b100) begin
            bad++; $display("FAIL oob_rd_cmd got=%b%b%b exp=100", bus.o_gnt0, bus.ce0, bus.we0);
        end
        cyc_start();
        idle();
        cyc_start();
        #4;
        total++;
        if ({bus.o_rvalid0, bus.o_rdata0} !== {1'b1, 16'h0}) begin
            bad++; $display("FAIL oob_rd_resp got=%b d=%h exp=1 d=0", bus.o_rvalid0, bus.o_rdata0);
        end
        cyc_start();
        req1(1'b1, 7'd120, 16'hBEEF);
        #4;
        total++;
        if ({bus.o_gnt1, bus.ce0, bus.we0} !== 3'b100) begin
            bad++; $display("FAIL oob_wr_cmd got=%b%b%b exp=100", bus.o_gnt1, bus.ce0, bus.we0);
        end
        cyc_start();
        idle();
        #4;
        total++;
        if (mem[120] !== 16'h0) begin bad++; $display("FAIL oob_wr_mem got=%h exp=0", mem[120]); end
        cyc_start();
        // read in flight when reset arrives must never answer
        req0(1'b0, 7'd10, 16'h0);
        cyc_start();
        reset = 1'b1;
        #4;
        total++;
        if ({bus.o_gnt0, bus.ce0} !== 2'b00) begin
            bad++; $display("FAIL rst_gnt_forced got=%b%b exp=00", bus.o_gnt0, bus.ce0);
        end
        cyc_start();
        reset = 1'b0;
        idle();
        #4;
        total++;
        if ({bus.o_rvalid0, bus.o_rvalid1} !== 2'b00) begin
            bad++; $display("FAIL rst_flush got=%b exp=00", {bus.o_rvalid0, bus.o_rvalid1});
        end
        cyc_start();
    endtask

    task automatic test_random();
        bit            pend[2];
        bit            pwe[2];
        logic [AW-1:0] paddr[2];
        logic [DW-1:0] pdata[2];
        logic [DW-1:0] shadow[128];
        logic [DW-1:0] last_rd[2];
        rd_t           rq[$];
        rd_t           item;
        int            g, cycn;
        bit            e_ce, e_we, e_rv0, e_rv1;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_d;
        do_reset();
        hist.delete();
        for (int i = 0; i < 128; i++) shadow[i] = mem[i];
        last_rd[0] = '0;
        last_rd[1] = '0;
        pend[0] = 0;
        pend[1] = 0;
        cycn = 0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 9) < 6) begin
                    pend[r]  = 1;
                    pwe[r]   = ($urandom_range(0, 2) == 0);
                    paddr[r] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 127)) : AW'($urandom_range(0, 15));
                    pdata[r] = DW'($urandom);
                end
            end
            idle();
            if (pend[0]) req0(pwe[0], paddr[0], pdata[0]);
            if (pend[1]) req1(pwe[1], paddr[1], pdata[1]);
            #4;
            g = model_pick(pend[0], pend[1]);
            e_ce = 0; e_we = 0; e_addr = '0; e_d = '0;
            if (g >= 0) begin
                e_ce   = (int'(paddr[g]) < MS);
                e_we   = e_ce && pwe[g];
                e_addr = paddr[g];
                e_d    = pdata[g];
            end
            e_rv0 = 0; e_rv1 = 0;
            if (rq.size() > 0 && rq[0].cyc + 2 == cycn) begin
                item = rq.pop_front();
                if (item.id == 0) e_rv0 = 1; else e_rv1 = 1;
                last_rd[item.id] = item.data;
            end
            total++;
            if ({bus.o_gnt0, bus.o_gnt1, bus.ce0, bus.we0, bus.addr0, bus.d0} !==
                {g == 0, g == 1, e_ce, e_we, e_addr, e_d}) begin
                bad++; $display("FAIL rand_cmd cyc%0d got=%b%b%b%b a=%0d d=%h exp=%b%b%b%b a=%0d d=%h", cycn,
                                bus.o_gnt0, bus.o_gnt1, bus.ce0, bus.we0, bus.addr0, bus.d0,
                                g == 0, g == 1, e_ce, e_we, e_addr, e_d);
            end
            total++;
            if ({bus.o_rvalid0, bus.o_rvalid1, bus.o_rdata0, bus.o_rdata1} !==
                {e_rv0, e_rv1, last_rd[0], last_rd[1]}) begin
                bad++; $display("FAIL rand_resp cyc%0d got=%b%b d0=%h d1=%h exp=%b%b d0=%h d1=%h", cycn,
                                bus.o_rvalid0, bus.o_rvalid1, bus.o_rdata0, bus.o_rdata1,
                                e_rv0, e_rv1, last_rd[0], last_rd[1]);
            end
            if (g >= 0) begin
                if (!pwe[g]) begin
                    item.cyc  = cycn;
                    item.id   = g;
                    item.data = (int'(paddr[g]) < MS) ? shadow[paddr[g]] : '0;
                    rq.push_back(item);
                end else if (int'(paddr[g]) < MS) begin
                    shadow[paddr[g]] = pdata[g];
                end
                pend[g] = 0;
            end
            hist.push_back(g);
            cycn++;
            cyc_start();
        end
        idle();
        cyc_start();
    endtask

    initial begin
        idle();
        cyc_start();
        test_reset();
        test_write_read();
        test_burst();
        test_drop();
        test_mixed_reads();
        test_out_of_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
